// File: rtl/alu_operand_sequencer.sv
// Operand/opcode entry sequencer that drives a combinational ALU.
// Collects OP1, OP2 and OpCode step by step, then registers the result.
module alu_operand_sequencer #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] data_in,
    input  logic         enter,
    input  logic         undo,
    input  logic [N-1:0] alu_result,
    output logic [N-1:0] OP1,
    output logic [N-1:0] OP2,
    output logic [3:0]   OpCode,
    output logic [N-1:0] display,
    output logic [3:0]   state_leds,
    output logic         done,
    output logic         err
);

    typedef enum logic [2:0] {
        S_OP1,
        S_OP2,
        S_OPC,
        S_EXEC,
        S_SHOW
    } state_t;

    state_t       state;
    state_t       state_n;
    logic [N-1:0] result;
    logic         ld_op1;
    logic         ld_op2;
    logic         ld_opc;
    logic         ld_res;
    logic         bad_opc;
    logic         opc_ok;

    assign opc_ok = data_in[3:0] inside {4'b0000, 4'b0100, 4'b0010,
                                         4'b0101, 4'b0001};

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_OP1;
        else       state <= state_n;
    end

    // Next-state and load strobes; undo always wins over enter
    always_comb begin
        state_n = state;
        ld_op1  = 1'b0;
        ld_op2  = 1'b0;
        ld_opc  = 1'b0;
        ld_res  = 1'b0;
        bad_opc = 1'b0;
        unique case (state)
            S_OP1: begin
                if (enter && !undo) begin
                    ld_op1  = 1'b1;
                    state_n = S_OP2;
                end
            end
            S_OP2: begin
                if (undo) begin
                    state_n = S_OP1;
                end else if (enter) begin
                    ld_op2  = 1'b1;
                    state_n = S_OPC;
                end
            end
            S_OPC: begin
                if (undo) begin
                    state_n = S_OP2;
                end else if (enter) begin
                    if (opc_ok) begin
                        ld_opc  = 1'b1;
                        state_n = S_EXEC;
                    end else begin
                        bad_opc = 1'b1;
                    end
                end
            end
            S_EXEC: begin
                ld_res  = 1'b1;
                state_n = S_SHOW;
            end
            S_SHOW: begin
                if (undo)       state_n = S_OPC;
                else if (enter) state_n = S_OP1;
            end
            default: state_n = S_OP1;
        endcase
    end

    // Operand, opcode, result and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            OP1    <= '0;
            OP2    <= '0;
            OpCode <= 4'b0000;
            result <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (ld_op1) OP1    <= data_in;
            if (ld_op2) OP2    <= data_in;
            if (ld_opc) OpCode <= data_in[3:0];
            if (ld_res) result <= alu_result;
            done <= (state_n == S_SHOW);
            err  <= bad_opc;
        end
    end

    // Display source and step indicator decoded from state
    always_comb begin
        display    = data_in;
        state_leds = 4'b0001;
        unique case (state)
            S_OP1: begin
                display    = data_in;
                state_leds = 4'b0001;
            end
            S_OP2: begin
                display    = data_in;
                state_leds = 4'b0010;
            end
            S_OPC: begin
                display    = {{(N-4){1'b0}}, data_in[3:0]};
                state_leds = 4'b0100;
            end
            S_EXEC: begin
                display    = result;
                state_leds = 4'b0100;
            end
            S_SHOW: begin
                display    = result;
                state_leds = 4'b1000;
            end
            default: begin
                display    = data_in;
                state_leds = 4'b0001;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed testbench for alu_operand_sequencer.
// Uses a small behavioural ALU on the OP1/OP2/OpCode interface.
module tb_alu_operand_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    logic        enter;
    logic        undo;
    logic [15:0] alu_result;
    logic [15:0] OP1;
    logic [15:0] OP2;
    logic [3:0]  OpCode;
    logic [15:0] display;
    logic [3:0]  state_leds;
    logic        done;
    logic        err;

    int checks = 0;
    int failures = 0;

    alu_operand_sequencer #(.N(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .enter      (enter),
        .undo       (undo),
        .alu_result (alu_result),
        .OP1        (OP1),
        .OP2        (OP2),
        .OpCode     (OpCode),
        .display    (display),
        .state_leds (state_leds),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Behavioural ALU, N-bit truncated
    always_comb begin
        alu_result = 16'h0000;
        case (OpCode)
            4'b0000: alu_result = OP1 + OP2;
            4'b0100: alu_result = OP1 - OP2;
            4'b0010: alu_result = OP1 & OP2;
            4'b0101: alu_result = OP1 | OP2;
            4'b0001: alu_result = OP1 * OP2;
            default: alu_result = 16'h0000;
        endcase
    end

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic press_enter(input logic [15:0] v);
        data_in = v;
        enter = 1'b1;
        @(posedge clk);
        #1;
        enter = 1'b0;
    endtask

    task automatic press_undo();
        undo = 1'b1;
        @(posedge clk);
        #1;
        undo = 1'b0;
    endtask

    task automatic test_reset();
        data_in = 16'hABCD;
        #1;
        checks++;
        if (OP1 !== 16'h0 || OP2 !== 16'h0 || OpCode !== 4'h0) begin
            failures++;
            $display("FAIL reset_regs OP1=%h OP2=%h OpCode=%h want 0",
                     OP1, OP2, OpCode);
        end
        checks++;
        if (state_leds !== 4'b0001 || done !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL reset_status leds=%b done=%b err=%b want 0001/0/0",
                     state_leds, done, err);
        end
        checks++;
        if (display !== 16'hABCD) begin
            failures++;
            $display("FAIL reset_echo display=%h want abcd", display);
        end
    endtask

    task automatic test_add();
        press_enter(16'h0005);
        checks++;
        if (state_leds !== 4'b0010 || OP1 !== 16'h0005) begin
            failures++;
            $display("FAIL add_op1 leds=%b OP1=%h want 0010/0005",
                     state_leds, OP1);
        end
        press_enter(16'h0003);
        press_enter(16'h0000);
        checks++;
        if (OP1 !== 16'h0005 || OP2 !== 16'h0003 || state_leds !== 4'b0100
            || done !== 1'b0) begin
            failures++;
            $display("FAIL add_exec OP1=%h OP2=%h leds=%b done=%b",
                     OP1, OP2, state_leds, done);
        end
        idle();
        checks++;
        if (display !== 16'h0008 || done !== 1'b1 || state_leds !== 4'b1000) begin
            failures++;
            $display("FAIL add_result display=%h done=%b leds=%b want 0008/1/1000",
                     display, done, state_leds);
        end
    endtask

    task automatic test_sub_undo();
        press_enter(16'h0000);
        checks++;
        if (state_leds !== 4'b0001 || done !== 1'b0 || OP1 !== 16'h0005) begin
            failures++;
            $display("FAIL show_enter leds=%b done=%b OP1=%h want 0001/0/0005",
                     state_leds, done, OP1);
        end
        press_enter(16'h0003);
        press_enter(16'h0005);
        press_enter(16'h0004);
        idle();
        checks++;
        if (display !== 16'hFFFE) begin
            failures++;
            $display("FAIL sub_wrap display=%h want fffe", display);
        end
        press_undo();
        checks++;
        if (state_leds !== 4'b0100 || done !== 1'b0) begin
            failures++;
            $display("FAIL show_undo leds=%b done=%b want 0100/0",
                     state_leds, done);
        end
        press_enter(16'h0001);
        idle();
        checks++;
        if (display !== 16'h000F || OP1 !== 16'h0003 || OP2 !== 16'h0005
            || OpCode !== 4'b0001 || done !== 1'b1) begin
            failures++;
            $display("FAIL mul_reuse display=%h OP1=%h OP2=%h OpCode=%b done=%b",
                     display, OP1, OP2, OpCode, done);
        end
    endtask

    task automatic test_mul_trunc();
        press_enter(16'h0000);
        press_enter(16'h0100);
        press_enter(16'h0100);
        press_enter(16'h0001);
        idle();
        checks++;
        if (display !== 16'h0000 || done !== 1'b1) begin
            failures++;
            $display("FAIL mul_trunc display=%h done=%b want 0000/1",
                     display, done);
        end
    endtask

    task automatic test_bad_opcode();
        press_enter(16'h0000);
        press_enter(16'h00F0);
        press_enter(16'h000F);
        data_in = 16'hABC7;
        #1;
        checks++;
        if (display !== 16'h0007) begin
            failures++;
            $display("FAIL opc_echo display=%h want 0007", display);
        end
        press_enter(16'h0003);
        checks++;
        if (err !== 1'b1 || state_leds !== 4'b0100 || OpCode !== 4'b0001) begin
            failures++;
            $display("FAIL bad_opc err=%b leds=%b OpCode=%b want 1/0100/0001",
                     err, state_leds, OpCode);
        end
        idle();
        checks++;
        if (err !== 1'b0 || state_leds !== 4'b0100) begin
            failures++;
            $display("FAIL err_pulse err=%b leds=%b want 0/0100",
                     err, state_leds);
        end
        press_enter(16'h0005);
        idle();
        checks++;
        if (display !== 16'h00FF || err !== 1'b0) begin
            failures++;
            $display("FAIL or_result display=%h err=%b want 00ff/0",
                     display, err);
        end
    endtask

    task automatic test_enter_undo_same();
        press_enter(16'h0000);
        press_enter(16'h1111);
        data_in = 16'h2222;
        enter = 1'b1;
        undo = 1'b1;
        idle();
        enter = 1'b0;
        undo = 1'b0;
        checks++;
        if (state_leds !== 4'b0001 || OP2 !== 16'h000F || OP1 !== 16'h1111) begin
            failures++;
            $display("FAIL both_press leds=%b OP1=%h OP2=%h want 0001/1111/000f",
                     state_leds, OP1, OP2);
        end
        press_undo();
        checks++;
        if (state_leds !== 4'b0001 || OP1 !== 16'h1111 || display !== 16'h2222) begin
            failures++;
            $display("FAIL undo_op1 leds=%b OP1=%h display=%h want 0001/1111/2222",
                     state_leds, OP1, display);
        end
    endtask

    task automatic test_reset_mid();
        press_enter(16'h1234);
        press_enter(16'h5678);
        checks++;
        if (state_leds !== 4'b0100 || OP1 !== 16'h1234 || OP2 !== 16'h5678) begin
            failures++;
            $display("FAIL pre_reset leds=%b OP1=%h OP2=%h", state_leds, OP1, OP2);
        end
        data_in = 16'h9A5C;
        reset = 1'b1;
        idle();
        reset = 1'b0;
        checks++;
        if (OP1 !== 16'h0 || OP2 !== 16'h0 || OpCode !== 4'h0 || done !== 1'b0
            || state_leds !== 4'b0001 || display !== 16'h9A5C) begin
            failures++;
            $display("FAIL mid_reset OP1=%h OP2=%h OpCode=%h done=%b leds=%b disp=%h",
                     OP1, OP2, OpCode, done, state_leds, display);
        end
    endtask

    initial begin
        reset = 1'b1;
        data_in = 16'h0000;
        enter = 1'b0;
        undo = 1'b0;
        idle();
        idle();
        reset = 1'b0;
        test_reset();
        test_add();
        test_sub_undo();
        test_mul_trunc();
        test_bad_opcode();
        test_enter_undo_same();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
